csa_window_accumulator: RTL and testbench
=========================================

Name: csa_window_accumulator

Overview:
Downstream consumer of the correlator's 3:2 carry-save compression stage. Takes per-cycle carry-save pairs (C, S) and accumulates them over a window of NSUM valid samples, keeping the running sum in redundant form. At window end it performs one carry-propagate add and emits a saturated binary correlation sum to the peak-finding logic.

Parameters:
NBITS, 4, width of input C and S vectors.
NSUM, 16, valid samples per window; legal range 2..256.
ACCBITS, 12, output sum width; output saturates at 2^ACCBITS-1.

Ports:
clk_i  input  1  system clock; all logic on the rising edge.
rst_i  input  1  synchronous, active-high reset.
valid_i  input  1  c_i/s_i carry a sample this cycle.
c_i  input  NBITS  carry vector, bit weight 2^(i+1).
s_i  input  NBITS  sum vector, bit weight 2^i.
flush_i  input  1  abort current window and discard its partial sum.
sum_o  output  ACCBITS  window sum, saturated.
sum_valid_o  output  1  one-cycle pulse qualifying sum_o and sat_o.
sat_o  output  1  window's true sum exceeded 2^ACCBITS-1.
busy_o  output  1  at least one sample accepted in the current window.

Behaviour:
- Sample value is S + 2*C, range 0..3*(2^NBITS-1).
- Internal width W = NBITS + 2 + clog2(NSUM). W must never wrap; no modular arithmetic is allowed internally.
- Accumulator holds acc_s and acc_c, each W bits.
- On an accepted sample, {acc_s, acc_c, s_i, c_i<<1} is reduced by a 4:2 compressor (two cascaded 3:2 levels) and registered. There is no carry propagation in the loop.
- cnt (clog2(NSUM) bits) counts accepted samples. It holds when valid_i=0; gaps between samples are allowed.
- Last sample (valid_i=1, cnt=NSUM-1):
  - The compressed result loads into the dump pair (dmp_s, dmp_c), and dmp_v is set.
  - acc and cnt clear on the same edge, so the next cycle may begin a new window with no bubble.
- Final stage: T = dmp_s + dmp_c, as a W-bit carry-propagate add registered into sum_o.
  - sum_o = min(T, 2^ACCBITS-1).
  - sat_o = (T > 2^ACCBITS-1).
  - sum_valid_o = dmp_v delayed one cycle.
- Latency: last sample presented in cycle k gives sum_valid_o high in cycle k+2, for exactly one cycle.
- Throughput: one window per NSUM cycles when samples arrive back-to-back.
- sum_o and sat_o hold their value until the next pulse.
- flush_i=1:
  - acc and cnt clear on the next edge; busy_o goes to 0.
  - Flush wins over a simultaneous valid_i, and that sample is discarded.
  - Flush does not cancel a dump already in the dmp or output stage.
- busy_o = (cnt != 0), registered with cnt.
- Reset values: acc_s, acc_c, cnt, dmp_s, dmp_c, dmp_v = 0; sum_o = 0; sum_valid_o = 0; sat_o = 0; busy_o = 0.
- Reset mid-window or mid-dump discards all state. No pulse is emitted for the interrupted window.
- X on c_i/s_i while valid_i=0 must not corrupt state.

Decomposition:
- Shared package (correlator_pkg): a clog2 constant function, and a function computing W from NBITS and NSUM.
- One sub-module, csa_compress_4to2: combinational, parameter W, four W-bit inputs, outputs C and S.
  - Built as two 3:2 levels.
  - Carry output is left-shifted inside it, with the MSB carry dropped. This is safe because of how W is sized.
- Counter, dump register and CPA/saturation stay in the top module.

Test Plan:
1. NBITS=4, NSUM=4, ACCBITS=8; four back-to-back samples c=1, s=1 -> sum_o=12, sat_o=0, sum_valid_o pulses at cycle k+2 after the 4th sample.
2. Same parameters; four samples c=15, s=15 -> sum_o=180. Rerun with ACCBITS=6 -> sum_o=63, sat_o=1.
3. Samples with gaps (valid_i pattern 1,0,0,1,1,0,1), values 0..3 in varying c/s splits -> sum equals the reference integer sum; busy_o=1 from the first sample until the dump.
4. Eight consecutive samples (two windows, values 1..8), no idle cycle -> two pulses 4 cycles apart with sum_o=10 then 26.
5. Two samples, then flush_i together with a valid sample, then four samples value 2 -> no pulse for the aborted window; next sum_o=8.
6. rst_i asserted the cycle after a window's last sample -> no sum_valid_o pulse; all outputs 0; the next full window sums correctly.

Source files
------------

// File: rtl/correlator_pkg.sv
// Shared sizing helpers for the correlator datapath blocks.
package correlator_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width: sample needs NBITS+2 bits, plus growth over NSUM samples.
    function automatic int calc_w(input int nbits, input int nsum);
        return nbits + 2 + clog2(nsum);
    endfunction

endpackage

// File: rtl/csa_compress_4to2.sv
// Combinational 4:2 carry-save compressor built from two cascaded 3:2 levels.
module csa_compress_4to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] c_o
);

    logic [W-1:0] s1_s;
    logic [W-1:0] m1_s;
    logic [W-1:0] c1_s;
    logic [W-1:0] m2_s;

    assign s1_s = a_i ^ b_i ^ c_i;
    assign m1_s = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    // The caller sizes W so the total never reaches 2^W; the dropped MSB carry is always zero.
    assign c1_s = {m1_s[W-2:0], 1'b0};

    assign s_o  = s1_s ^ c1_s ^ d_i;
    assign m2_s = (s1_s & c1_s) | (s1_s & d_i) | (c1_s & d_i);
    assign c_o  = {m2_s[W-2:0], 1'b0};

endmodule

// File: rtl/csa_window_accumulator.sv
// Accumulates carry-save sample pairs over NSUM valid samples in redundant form,
// then resolves the window with one carry-propagate add and saturates the result.
module csa_window_accumulator
    import correlator_pkg::*;
#(
    parameter int NBITS   = 4,
    parameter int NSUM    = 16,
    parameter int ACCBITS = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [NBITS-1:0]   c_i,
    input  logic [NBITS-1:0]   s_i,
    input  logic               flush_i,
    output logic [ACCBITS-1:0] sum_o,
    output logic               sum_valid_o,
    output logic               sat_o,
    output logic               busy_o
);

    localparam int W    = calc_w(NBITS, NSUM);
    localparam int CNTW = clog2(NSUM);
    localparam int CW   = (W > ACCBITS) ? W : ACCBITS;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NSUM - 1);
    localparam logic [CW-1:0]   SAT_MAX  = CW'({ACCBITS{1'b1}});

    logic [W-1:0]       acc_s_q, acc_s_d;
    logic [W-1:0]       acc_c_q, acc_c_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [W-1:0]       dmp_s_q, dmp_s_d;
    logic [W-1:0]       dmp_c_q, dmp_c_d;
    logic               dmp_v_q, dmp_v_d;
    logic [ACCBITS-1:0] sum_q, sum_d;
    logic               sat_q, sat_d;
    logic               sum_valid_q, sum_valid_d;

    logic [W-1:0]  s_in_s;
    logic [W-1:0]  c_in_s;
    logic [W-1:0]  cmp_s_s;
    logic [W-1:0]  cmp_c_s;
    logic [W-1:0]  t_s;
    logic [CW-1:0] t_ext_s;
    logic          over_s;

    // Gating with valid_i keeps X on idle inputs out of the compressor.
    assign s_in_s = valid_i ? {{(W-NBITS){1'b0}}, s_i} : {W{1'b0}};
    assign c_in_s = valid_i ? {{(W-NBITS-1){1'b0}}, c_i, 1'b0} : {W{1'b0}};

    csa_compress_4to2 #(
        .W(W)
    ) u_compress (
        .a_i (acc_s_q),
        .b_i (acc_c_q),
        .c_i (s_in_s),
        .d_i (c_in_s),
        .s_o (cmp_s_s),
        .c_o (cmp_c_s)
    );

    // Window accumulation, sample counting and hand-off to the dump pair.
    always_comb begin
        acc_s_d = acc_s_q;
        acc_c_d = acc_c_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        dmp_s_d = dmp_s_q;
        dmp_c_d = dmp_c_q;
        dmp_v_d = 1'b0;
        if (flush_i) begin
            acc_s_d = {W{1'b0}};
            acc_c_d = {W{1'b0}};
            cnt_d   = {CNTW{1'b0}};
            busy_d  = 1'b0;
        end else if (valid_i) begin
            if (cnt_q == LAST_CNT) begin
                dmp_s_d = cmp_s_s;
                dmp_c_d = cmp_c_s;
                dmp_v_d = 1'b1;
                acc_s_d = {W{1'b0}};
                acc_c_d = {W{1'b0}};
                cnt_d   = {CNTW{1'b0}};
                busy_d  = 1'b0;
            end else begin
                acc_s_d = cmp_s_s;
                acc_c_d = cmp_c_s;
                cnt_d   = cnt_q + CNTW'(1);
                busy_d  = 1'b1;
            end
        end else begin
            busy_d = busy_q;
        end
    end

    assign t_s     = dmp_s_q + dmp_c_q;
    assign t_ext_s = CW'(t_s);
    assign over_s  = (t_ext_s > SAT_MAX);

    // Final carry-propagate add with saturation; result holds between pulses.
    always_comb begin
        sum_d       = sum_q;
        sat_d       = sat_q;
        sum_valid_d = dmp_v_q;
        if (dmp_v_q) begin
            sum_d = over_s ? {ACCBITS{1'b1}} : t_ext_s[ACCBITS-1:0];
            sat_d = over_s;
        end else begin
            sat_d = sat_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_s_q     <= {W{1'b0}};
            acc_c_q     <= {W{1'b0}};
            cnt_q       <= {CNTW{1'b0}};
            busy_q      <= 1'b0;
            dmp_s_q     <= {W{1'b0}};
            dmp_c_q     <= {W{1'b0}};
            dmp_v_q     <= 1'b0;
            sum_q       <= {ACCBITS{1'b0}};
            sat_q       <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            dmp_s_q     <= dmp_s_d;
            dmp_c_q     <= dmp_c_d;
            dmp_v_q     <= dmp_v_d;
            sum_q       <= sum_d;
            sat_q       <= sat_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_o       = sum_q;
    assign sat_o       = sat_q;
    assign sum_valid_o = sum_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_csa_window_accumulator.sv
// Scoreboard bench: two instances (ACCBITS 8 and 6) share stimulus; expected
// window sums are pushed as samples are accepted and checked on each pulse.
module tb_csa_window_accumulator;

    localparam int NS = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       flush_i;
    logic [3:0] c_i;
    logic [3:0] s_i;

    logic [7:0] a_sum;
    logic       a_sv, a_sat, a_busy;
    logic [5:0] b_sum;
    logic       b_sv, b_sat, b_busy;

    typedef struct {
        int sum;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   m_sum = 0;
    int   m_cnt = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    csa_window_accumulator #(.NBITS(4), .NSUM(NS), .ACCBITS(8)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .c_i(c_i), .s_i(s_i),
        .flush_i(flush_i), .sum_o(a_sum), .sum_valid_o(a_sv), .sat_o(a_sat), .busy_o(a_busy)
    );

    csa_window_accumulator #(.NBITS(4), .NSUM(NS), .ACCBITS(6)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .c_i(c_i), .s_i(s_i),
        .flush_i(flush_i), .sum_o(b_sum), .sum_valid_o(b_sv), .sat_o(b_sat), .busy_o(b_busy)
    );

    // One clock of stimulus; the reference model tracks accepted samples.
    task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] s, input logic f);
        valid_i = v;
        c_i     = c;
        s_i     = s;
        flush_i = f;
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            m_sum = 0;
            m_cnt = 0;
        end else if (f) begin
            m_sum = 0;
            m_cnt = 0;
        end else if (v) begin
            m_sum = m_sum + int'(s) + 2 * int'(c);
            m_cnt = m_cnt + 1;
            if (m_cnt == NS) begin
                sb.push_back('{m_sum, cyc + 1});
                m_sum = 0;
                m_cnt = 0;
            end
        end
        valid_i = 1'b0;
        c_i     = 4'bxxxx;
        s_i     = 4'bxxxx;
        flush_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'bxxxx, 4'bxxxx, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            idle(1);
            budget++;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL drain: %0d pending windows, required 0", sb.size());
        else passed++;
    endtask

    task automatic monitor();
        exp_t e;
        int   e8, e6;
        forever begin
            @(negedge clk_i);
            if (a_sv) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_pulse: sum=%0d at cycle %0d, required no pulse", a_sum, cyc);
                end else begin
                    e  = sb.pop_front();
                    e8 = (e.sum > 255) ? 255 : e.sum;
                    e6 = (e.sum > 63) ? 63 : e.sum;
                    if (a_sum !== 8'(e8) || a_sat !== (e.sum > 255))
                        $display("FAIL sum8: got %0d sat %0b, required %0d sat %0b", a_sum, a_sat, e8, e.sum > 255);
                    else passed++;
                    checks++;
                    if (b_sv !== 1'b1 || b_sum !== 6'(e6) || b_sat !== (e.sum > 63))
                        $display("FAIL sum6: got v%0b %0d sat %0b, required v1 %0d sat %0b", b_sv, b_sum, b_sat, e6, e.sum > 63);
                    else passed++;
                    checks++;
                    if (cyc !== e.cyc)
                        $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
                    else passed++;
                end
            end else if (b_sv) begin
                checks++;
                $display("FAIL stray_pulse6: sum=%0d at cycle %0d, required no pulse", b_sum, cyc);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({a_sum, a_sat, a_sv, a_busy} !== 11'd0 || {b_sum, b_sat, b_sv, b_busy} !== 9'd0)
            $display("FAIL %s: a=%0d/%0b/%0b/%0b b=%0d/%0b/%0b/%0b, required all 0",
                     name, a_sum, a_sat, a_sv, a_busy, b_sum, b_sat, b_sv, b_busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        check_idle_outputs("reset_state");
    endtask

    task automatic test_basic();
        for (int i = 0; i < NS; i++) drive(1'b1, 4'd1, 4'd1, 1'b0);
        drain();
        idle(2);
        checks++;
        if (a_sum !== 8'd12 || a_sv !== 1'b0)
            $display("FAIL hold: sum=%0d valid=%0b, required 12 valid 0", a_sum, a_sv);
        else passed++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < NS; i++) drive(1'b1, 4'd15, 4'd15, 1'b0);
        drain();
    endtask

    task automatic test_gaps();
        logic       vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] cv   [4] = '{4'd0, 4'd1, 4'd1, 4'd0};
        logic [3:0] sv   [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        int k;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (vpat[i]) begin
                drive(1'b1, cv[k], sv[k], 1'b0);
                k++;
            end else begin
                idle(1);
            end
            checks++;
            if (a_busy !== (m_cnt != 0))
                $display("FAIL busy_gap%0d: got %0b, required %0b", i, a_busy, m_cnt != 0);
            else passed++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int v = 1; v <= 8; v++) drive(1'b1, 4'(v >> 1), 4'(v & 1), 1'b0);
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 4'd1, 4'd0, 1'b0);
        drive(1'b1, 4'd1, 4'd0, 1'b0);
        drive(1'b1, 4'd1, 4'd1, 1'b1);
        checks++;
        if (a_busy !== 1'b0)
            $display("FAIL flush_busy: got %0b, required 0", a_busy);
        else passed++;
        for (int i = 0; i < NS; i++) drive(1'b1, 4'd1, 4'd0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NS; i++) drive(1'b1, 4'd0, 4'd1, 1'b0);
        void'(sb.pop_back());
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        check_idle_outputs("reset_mid_dump");
        idle(3);
        check_idle_outputs("reset_no_pulse");
        for (int i = 0; i < NS; i++) drive(1'b1, 4'd1, 4'd1, 1'b0);
        drain();
        checks++;
        if (a_sum !== 8'd12)
            $display("FAIL after_reset_sum: got %0d, required 12", a_sum);
        else passed++;
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        c_i     = 4'd0;
        s_i     = 4'd0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_saturate();
        test_gaps();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        idle(4);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
